// File: rtl/wb_cpu_master_pkg.sv
// Shared encodings for the CPU-to-Wishbone master:
// access sizes, FSM states, byte-lane select patterns.
package wb_cpu_master_pkg;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [3:0] SEL_BYTE = 4'b0001;
    localparam logic [3:0] SEL_HALF = 4'b0011;
    localparam logic [3:0] SEL_WORD = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_legal(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        case (size)
            SZ_BYTE: is_legal = 1'b1;
            SZ_HALF: is_legal = ~lo[0];
            SZ_WORD: is_legal = (lo == 2'b00);
            default: is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/wb_lane_align.sv
// Byte-lane steering: select generation and write replication for the
// outgoing request, lane extraction and extension for the returned data.
module wb_lane_align
    import wb_cpu_master_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    output logic [3:0]  o_sel,
    output logic [31:0] o_wdata,
    input  logic [1:0]  i_rd_size,
    input  logic [1:0]  i_rd_addr_lo,
    input  logic        i_rd_signed,
    input  logic [31:0] i_rd_data,
    output logic [31:0] o_rdata
);

    logic [31:0] w_shift;

    always_comb begin
        o_sel   = SEL_WORD;
        o_wdata = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_sel   = SEL_BYTE << i_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_sel   = SEL_HALF << i_addr_lo;
                o_wdata = {2{i_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    // Word accesses are always aligned, so the shift is zero for them.
    assign w_shift = i_rd_data >> {i_rd_addr_lo, 3'b000};

    always_comb begin
        o_rdata = w_shift;
        case (i_rd_size)
            SZ_BYTE: o_rdata = {{24{i_rd_signed & w_shift[7]}},
                                w_shift[7:0]};
            SZ_HALF: o_rdata = {{16{i_rd_signed & w_shift[15]}},
                                w_shift[15:0]};
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_cpu_master.sv
// CPU load/store port to single-beat Wishbone master with alignment
// checking, lane steering and a bus timeout.
module wb_cpu_master
    import wb_cpu_master_pkg::*;
#(
    parameter int ADDR_BITS      = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [1:0]           cpu_size,
    input  logic                 cpu_signed,
    input  logic [31:0]          cpu_wdata,
    output logic                 cpu_rdy,
    output logic                 cpu_done,
    output logic [31:0]          cpu_rdata,
    output logic                 cpu_err,
    output logic                 wbm_cs_o,
    output logic [ADDR_BITS-3:0] wbm_addr_o,
    output logic [3:0]           wbm_sel_o,
    output logic [31:0]          wbm_data_o,
    output logic                 wbm_we_o,
    input  logic [31:0]          wbm_data_i,
    input  logic                 wbm_ack_i
);

    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t               r_state;
    logic [7:0]           r_cnt;
    logic [1:0]           r_lo;
    logic [1:0]           r_size;
    logic                 r_signed;
    logic                 r_done;
    logic                 r_err;
    logic [31:0]          r_rdata;
    logic                 r_cs;
    logic [ADDR_BITS-3:0] r_addr;
    logic [3:0]           r_sel;
    logic [31:0]          r_wdat;
    logic                 r_we;

    logic [3:0]           w_sel;
    logic [31:0]          w_wdata;
    logic [31:0]          w_rdata;

    wb_lane_align u_align (
        .i_size       (cpu_size),
        .i_addr_lo    (cpu_addr[1:0]),
        .i_wdata      (cpu_wdata),
        .o_sel        (w_sel),
        .o_wdata      (w_wdata),
        .i_rd_size    (r_size),
        .i_rd_addr_lo (r_lo),
        .i_rd_signed  (r_signed),
        .i_rd_data    (wbm_data_i),
        .o_rdata      (w_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_lo     <= '0;
            r_size   <= '0;
            r_signed <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= '0;
            r_cs     <= 1'b0;
            r_addr   <= '0;
            r_sel    <= '0;
            r_wdat   <= '0;
            r_we     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (cpu_req) begin
                        if (is_legal(cpu_size, cpu_addr[1:0])) begin
                            r_cs     <= 1'b1;
                            r_addr   <= cpu_addr[ADDR_BITS-1:2];
                            r_sel    <= w_sel;
                            r_wdat   <= w_wdata;
                            r_we     <= cpu_we;
                            r_size   <= cpu_size;
                            r_signed <= cpu_signed;
                            r_lo     <= cpu_addr[1:0];
                            r_cnt    <= '0;
                            r_state  <= ST_BUS;
                        end else begin
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_done  <= 1'b1;
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_BUS: begin
                    // Ack is tested first so it beats a coincident timeout.
                    if (wbm_ack_i) begin
                        r_cs    <= 1'b0;
                        r_rdata <= r_we ? 32'd0 : w_rdata;
                        r_err   <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (r_cnt == TO_LAST) begin
                        r_cs    <= 1'b0;
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cpu_rdy    = (r_state == ST_IDLE) & ~rst;
    assign cpu_done   = r_done;
    assign cpu_err    = r_err;
    assign cpu_rdata  = r_rdata;
    assign wbm_cs_o   = r_cs;
    assign wbm_addr_o = r_addr;
    assign wbm_sel_o  = r_sel;
    assign wbm_data_o = r_wdat;
    assign wbm_we_o   = r_we;

endmodule

// File: tb/tb_wb_cpu_master.sv
// Directed bench for wb_cpu_master with a short bus timeout.
// Expected values are hand-computed constants.
module tb_wb_cpu_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [1:0]  cpu_size;
    logic        cpu_signed;
    logic [31:0] cpu_wdata;
    logic        cpu_rdy;
    logic        cpu_done;
    logic [31:0] cpu_rdata;
    logic        cpu_err;
    logic        wbm_cs_o;
    logic [29:0] wbm_addr_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_data_o;
    logic        wbm_we_o;
    logic [31:0] wbm_data_i;
    logic        wbm_ack_i;

    int passed = 0;
    int total  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    wb_cpu_master #(
        .ADDR_BITS      (32),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_size   (cpu_size),
        .cpu_signed (cpu_signed),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdy    (cpu_rdy),
        .cpu_done   (cpu_done),
        .cpu_rdata  (cpu_rdata),
        .cpu_err    (cpu_err),
        .wbm_cs_o   (wbm_cs_o),
        .wbm_addr_o (wbm_addr_o),
        .wbm_sel_o  (wbm_sel_o),
        .wbm_data_o (wbm_data_o),
        .wbm_we_o   (wbm_we_o),
        .wbm_data_i (wbm_data_i),
        .wbm_ack_i  (wbm_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic we, input logic [31:0] addr,
                       input logic [1:0] size, input logic sgn,
                       input logic [31:0] wd);
        cpu_req    = 1'b1;
        cpu_we     = we;
        cpu_addr   = addr;
        cpu_size   = size;
        cpu_signed = sgn;
        cpu_wdata  = wd;
    endtask

    initial begin
        rst        = 1'b1;
        cpu_req    = 1'b0;
        cpu_we     = 1'b0;
        cpu_addr   = '0;
        cpu_size   = '0;
        cpu_signed = 1'b0;
        cpu_wdata  = '0;
        wbm_data_i = '0;
        wbm_ack_i  = 1'b0;
        #1;
        chk("rst_cs",    32'(wbm_cs_o), 32'd0);
        chk("rst_done",  32'(cpu_done), 32'd0);
        chk("rst_rdy",   32'(cpu_rdy), 32'd0);
        chk("rst_rdata", cpu_rdata, 32'd0);
        chk("rst_sel",   32'(wbm_sel_o), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rdy_after_rst", 32'(cpu_rdy), 32'd1);
        tick();

        // word write, zero-wait ack
        req(1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
        chk("ww_rdy_N", 32'(cpu_rdy), 32'd1);
        tick();
        cpu_req = 1'b0;
        chk("ww_cs_N1",  32'(wbm_cs_o), 32'd1);
        chk("ww_addr",   32'(wbm_addr_o), 32'h4);
        chk("ww_sel",    32'(wbm_sel_o), 32'hF);
        chk("ww_data",   wbm_data_o, 32'hDEADBEEF);
        chk("ww_we",     32'(wbm_we_o), 32'd1);
        chk("ww_rdy_N1", 32'(cpu_rdy), 32'd0);
        chk("ww_done_N1", 32'(cpu_done), 32'd0);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("ww_done_N2", 32'(cpu_done), 32'd1);
        chk("ww_err",     32'(cpu_err), 32'd0);
        chk("ww_rdata",   cpu_rdata, 32'd0);
        chk("ww_cs_N2",   32'(wbm_cs_o), 32'd0);
        tick();
        chk("ww_done_N3", 32'(cpu_done), 32'd0);
        chk("ww_rdy_N3",  32'(cpu_rdy), 32'd1);

        // signed byte read at lane 3
        req(1'b0, 32'h3, 2'd0, 1'b1, 32'h0);
        tick();
        cpu_req = 1'b0;
        chk("sb_sel", 32'(wbm_sel_o), 32'h8);
        chk("sb_we",  32'(wbm_we_o), 32'd0);
        wbm_data_i = 32'h80123456;
        wbm_ack_i  = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("sb_done",  32'(cpu_done), 32'd1);
        chk("sb_rdata", cpu_rdata, 32'hFFFFFF80);
        tick();

        // unsigned byte read at lane 3
        req(1'b0, 32'h3, 2'd0, 1'b0, 32'h0);
        tick();
        cpu_req   = 1'b0;
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("ub_rdata", cpu_rdata, 32'h00000080);
        chk("ub_err",   32'(cpu_err), 32'd0);
        tick();
        chk("ub_hold", cpu_rdata, 32'h00000080);

        // timeout: never ack, cs high for 4 cycles
        req(1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
        tick();
        cpu_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("to_cs%0d", i), 32'(wbm_cs_o), 32'd1);
            chk($sformatf("to_nd%0d", i), 32'(cpu_done), 32'd0);
            tick();
        end
        chk("to_cs_end", 32'(wbm_cs_o), 32'd0);
        chk("to_done",   32'(cpu_done), 32'd1);
        chk("to_err",    32'(cpu_err), 32'd1);
        chk("to_rdata",  cpu_rdata, 32'd0);
        tick();

        // ack on the timeout edge wins
        req(1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
        tick();
        cpu_req = 1'b0;
        repeat (3) tick();
        chk("ta_cs4", 32'(wbm_cs_o), 32'd1);
        wbm_data_i = 32'h13579BDF;
        wbm_ack_i  = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("ta_done",  32'(cpu_done), 32'd1);
        chk("ta_err",   32'(cpu_err), 32'd0);
        chk("ta_rdata", cpu_rdata, 32'h13579BDF);
        tick();

        // signed half read, upper lane
        req(1'b0, 32'h102, 2'd1, 1'b1, 32'h0);
        tick();
        cpu_req = 1'b0;
        chk("hr_sel",  32'(wbm_sel_o), 32'hC);
        chk("hr_addr", 32'(wbm_addr_o), 32'h40);
        wbm_data_i = 32'hBEEF0000;
        wbm_ack_i  = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("hr_rdata", cpu_rdata, 32'hFFFFBEEF);
        tick();

        // half write upper lane, byte write lane 1
        req(1'b1, 32'h2, 2'd1, 1'b0, 32'hFFFF1234);
        tick();
        cpu_req = 1'b0;
        chk("hw_sel",  32'(wbm_sel_o), 32'hC);
        chk("hw_data", wbm_data_o, 32'h12341234);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        tick();
        req(1'b1, 32'h1, 2'd0, 1'b0, 32'h000000AB);
        tick();
        cpu_req = 1'b0;
        chk("bw_sel",  32'(wbm_sel_o), 32'h2);
        chk("bw_data", wbm_data_o, 32'hABABABAB);
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        tick();

        // misaligned half write: no bus cycle, error
        req(1'b1, 32'h1, 2'd1, 1'b0, 32'h1234);
        tick();
        cpu_req = 1'b0;
        chk("mis_cs",   32'(wbm_cs_o), 32'd0);
        chk("mis_done", 32'(cpu_done), 32'd1);
        chk("mis_err",  32'(cpu_err), 32'd1);
        tick();
        chk("mis_rdy", 32'(cpu_rdy), 32'd1);

        // illegal size
        req(1'b0, 32'h0, 2'd3, 1'b0, 32'h0);
        tick();
        cpu_req = 1'b0;
        chk("sz3_cs",  32'(wbm_cs_o), 32'd0);
        chk("sz3_err", 32'(cpu_err), 32'd1);
        tick();

        // stray ack in idle is ignored
        wbm_ack_i = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("stray_done", 32'(cpu_done), 32'd0);
        chk("stray_rdy",  32'(cpu_rdy), 32'd1);

        // reset mid-bus
        req(1'b0, 32'h8, 2'd2, 1'b0, 32'h0);
        tick();
        cpu_req = 1'b0;
        chk("mr_cs_pre", 32'(wbm_cs_o), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_cs_async", 32'(wbm_cs_o), 32'd0);
        chk("mr_rdy_rst",  32'(cpu_rdy), 32'd0);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mr_nodone%0d", i), 32'(cpu_done), 32'd0);
        end
        req(1'b0, 32'h8, 2'd2, 1'b0, 32'h0);
        tick();
        cpu_req = 1'b0;
        chk("mr_cs_new", 32'(wbm_cs_o), 32'd1);
        wbm_data_i = 32'hCAFEF00D;
        wbm_ack_i  = 1'b1;
        tick();
        wbm_ack_i = 1'b0;
        chk("mr_done",  32'(cpu_done), 32'd1);
        chk("mr_err",   32'(cpu_err), 32'd0);
        chk("mr_rdata", cpu_rdata, 32'hCAFEF00D);
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
